// File: rtl/usb_clk_pkg.sv
// -----------------------------------------------------------------------------
// usb_clk_pkg
// Shared definitions for the USB clock bring-up logic.
//   pll_seq_state_t : 2-bit state of the PLL lock sequencer
//   DEF_*           : default timing constants for the 27 MHz crystal clock
//   max3/cnt_width  : helpers for sizing the sequencer counter
// -----------------------------------------------------------------------------
package usb_clk_pkg;

    typedef enum logic [1:0] {
        ST_RST_PLL   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_seq_state_t;

    // 27 MHz crystal: ~1 us reset pulse, ~1 ms lock timeout, ~100 us stability
    localparam int DEF_RESET_CYCLES  = 27;
    localparam int DEF_LOCK_TIMEOUT  = 27000;
    localparam int DEF_STABLE_CYCLES = 2700;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // $clog2 of the largest terminal count; never narrower than one bit
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer with synchronous active-high reset.
// Each bit is synchronized independently, so only use it for signals whose
// bits carry no multi-bit relationship (levels, flags).
//   clk    : destination clock
//   i_srst : synchronous reset, clears both stages to 0
//   i_d    : asynchronous input
//   o_q    : synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (i_srst) begin
                    r_meta[gi] <= 1'b0;
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_meta[gi] <= i_d[gi];
                    r_sync[gi] <= r_meta[gi];
                end
            end
        end
    endgenerate

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Brings up the 12 MHz USB rPLL from the 27 MHz crystal clock: pulses the PLL
// RESET pin, qualifies the asynchronous LOCK output, and keeps the USB host
// logic in reset until LOCK has been continuously high long enough. Retries
// after a lock timeout, a loss of lock, or a software request, and counts
// retries/relocks (saturating) for debug.
//   clk          : 27 MHz crystal clock (only clock)
//   reset        : synchronous active-high reset
//   pll_lock     : rPLL LOCK, asynchronous
//   force_relock : single-cycle request to restart the sequence
//   pll_reset    : to rPLL RESET, active-high
//   usb_reset    : active-high reset for the USB domain (low only in RUN)
//   locked       : high only in RUN
//   relock_count : saturating count of retries and relocks
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import usb_clk_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       usb_reset,
    output logic       locked,
    output logic [7:0] relock_count
);

    localparam int CNT_W = cnt_width(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(STABLE_CYCLES - 1);

    pll_seq_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_reset;
    logic             r_usb_reset;
    logic             r_locked;
    logic [7:0]       r_relock_count;

    logic             w_lock_s;
    logic             w_restart;
    logic [7:0]       w_relock_inc;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk    (clk),
        .i_srst (reset),
        .i_d    (pll_lock),
        .o_q    (w_lock_s)
    );

    // Every path back into RST_PLL outside of reset counts as a relock.
    // A request while already pulsing RESET is dropped so the pulse is not
    // stretched.
    assign w_restart = (r_state != ST_RST_PLL) &&
                       (force_relock ||
                        (r_state == ST_WAIT_LOCK && !w_lock_s && r_cnt == LT_LAST) ||
                        (r_state == ST_RUN && !w_lock_s));

    assign w_relock_inc = (r_relock_count == 8'hFF) ? r_relock_count
                                                    : r_relock_count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RST_PLL;
            r_cnt          <= '0;
            r_pll_reset    <= 1'b1;
            r_usb_reset    <= 1'b1;
            r_locked       <= 1'b0;
            r_relock_count <= 8'd0;
        end else if (w_restart) begin
            r_state        <= ST_RST_PLL;
            r_cnt          <= '0;
            r_pll_reset    <= 1'b1;
            r_usb_reset    <= 1'b1;
            r_locked       <= 1'b0;
            r_relock_count <= w_relock_inc;
        end else begin
            case (r_state)
                ST_RST_PLL: begin
                    if (r_cnt == RC_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // timeout already handled by w_restart
                    if (w_lock_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // a dropout here is a glitch: requalify without re-pulsing RESET
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == SC_LAST) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_usb_reset <= 1'b0;
                        r_locked    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // loss of lock handled by w_restart; counter idles at 0
                    r_cnt <= '0;
                end
                default: begin
                    r_state     <= ST_RST_PLL;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_usb_reset <= 1'b1;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset    = r_pll_reset;
    assign usb_reset    = r_usb_reset;
    assign locked       = r_locked;
    assign relock_count = r_relock_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed stimulus for the PLL lock sequencer with RESET_CYCLES=4,
// LOCK_TIMEOUT=20, STABLE_CYCLES=8. A phase/elapsed-time model predicts the
// outputs every cycle; literal expectations pin key instants.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       usb_reset;
    logic       locked;
    logic [7:0] relock_count;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .usb_reset    (usb_reset),
        .locked       (locked),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Phases: pulsing RESET, waiting for lock, qualifying lock, running.
    // 'elapsed' counts completed cycles spent in the current phase.
    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_RUN   = 3;

    int m_phase   = PH_PULSE;
    int m_elapsed = 0;
    int m_relocks = 0;
    bit m_valid   = 1'b0;
    bit m_hist1   = 1'b0;   // pll_lock at previous edge
    bit m_hist2   = 1'b0;   // pll_lock two edges ago = what the FSM sees now

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk) begin
        bit seen;
        if (reset) begin
            m_hist1   = 1'b0;
            m_hist2   = 1'b0;
            m_phase   = PH_PULSE;
            m_elapsed = 0;
            m_relocks = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            seen    = m_hist2;
            m_hist2 = m_hist1;
            m_hist1 = pll_lock;
            if (m_phase != PH_PULSE && force_relock) begin
                m_phase = PH_PULSE; m_elapsed = 0; m_relocks = sat_inc(m_relocks);
            end else if (m_phase == PH_PULSE) begin
                m_elapsed++;
                if (m_elapsed == RC) begin m_phase = PH_WAIT; m_elapsed = 0; end
            end else if (m_phase == PH_WAIT) begin
                if (seen) begin
                    m_phase = PH_QUAL; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == LT) begin
                        m_phase = PH_PULSE; m_elapsed = 0; m_relocks = sat_inc(m_relocks);
                    end
                end
            end else if (m_phase == PH_QUAL) begin
                if (!seen) begin
                    m_phase = PH_WAIT; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == SC) begin m_phase = PH_RUN; m_elapsed = 0; end
                end
            end else begin
                if (!seen) begin
                    m_phase = PH_PULSE; m_elapsed = 0; m_relocks = sat_inc(m_relocks);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pll_reset", int'(pll_reset), int'(m_phase == PH_PULSE));
            check("model_usb_reset", int'(usb_reset), int'(m_phase != PH_RUN));
            check("model_locked", int'(locked), int'(m_phase == PH_RUN));
            check("model_relock_count", int'(relock_count), m_relocks);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset        = 1'b1;
        pll_lock     = 1'b0;
        force_relock = 1'b0;

        // Power-up: 3 reset cycles, then a 4-cycle RESET pulse
        repeat (3) @(negedge clk);
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_usb_reset", int'(usb_reset), 1);
        check("rst_locked", int'(locked), 0);
        check("rst_relock_count", int'(relock_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pwr_pll_reset_high", int'(pll_reset), 1);
        end
        @(negedge clk);
        check("pwr_pll_reset_low", int'(pll_reset), 0);
        check("pwr_usb_reset", int'(usb_reset), 1);

        // Clean lock: LOCK rises 5 cycles after RESET falls (edge k)
        repeat (4) @(negedge clk);
        pll_lock = 1'b1;
        repeat (10) @(negedge clk);           // after edge k+9
        check("lock_usb_reset_k9", int'(usb_reset), 1);
        @(negedge clk);                       // after edge k+10
        check("lock_usb_reset_k10", int'(usb_reset), 0);
        check("lock_locked_k10", int'(locked), 1);
        check("lock_relock_count", int'(relock_count), 0);

        // Loss of lock in RUN
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);            // after edge j+1
        check("loss_usb_reset_j1", int'(usb_reset), 0);
        @(negedge clk);                       // after edge j+2
        check("loss_usb_reset_j2", int'(usb_reset), 1);
        check("loss_pll_reset_j2", int'(pll_reset), 1);
        check("loss_relock_count", int'(relock_count), 1);

        // Lock timeout: RESET re-pulses every 24 cycles
        repeat (23) @(negedge clk);
        check("tmo_pll_reset_low", int'(pll_reset), 0);
        check("tmo_count_before", int'(relock_count), 1);
        @(negedge clk);
        check("tmo_pll_reset_again", int'(pll_reset), 1);
        check("tmo_count_2", int'(relock_count), 2);
        repeat (24) @(negedge clk);
        check("tmo_count_3", int'(relock_count), 3);

        // Glitch during qualification (E = this RESET entry)
        pll_lock = 1'b1;
        repeat (7) @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        for (int i = 10; i < 20; i++) begin
            @(negedge clk);
            check("glitch_locked_low", int'(locked), 0);
            check("glitch_no_pll_reset", int'(pll_reset), 0);
        end
        @(negedge clk);                       // after edge E+20
        check("glitch_locked_high", int'(locked), 1);
        check("glitch_relock_count", int'(relock_count), 3);

        // Software relock from RUN
        force_relock = 1'b1;
        @(negedge clk);
        force_relock = 1'b0;
        check("force_usb_reset", int'(usb_reset), 1);
        check("force_pll_reset", int'(pll_reset), 1);
        check("force_relock_count", int'(relock_count), 4);

        // Request during the RESET pulse is ignored
        force_relock = 1'b1;
        @(negedge clk);
        force_relock = 1'b0;
        check("force_in_rst_ignored", int'(relock_count), 4);
        repeat (3) @(negedge clk);
        check("force_in_rst_pulse_len", int'(pll_reset), 0);

        // 300 forced relocks: counter saturates
        for (int i = 0; i < 300; i++) begin
            force_relock = 1'b1;
            @(negedge clk);
            force_relock = 1'b0;
            if (i == 0) check("sat_first", int'(relock_count), 5);
            repeat (4) @(negedge clk);
        end
        check("sat_255", int'(relock_count), 255);

        // Reset mid-qualification
        force_relock = 1'b1;
        @(negedge clk);
        force_relock = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_pll_reset", int'(pll_reset), 1);
        check("midrst_usb_reset", int'(usb_reset), 1);
        check("midrst_locked", int'(locked), 0);
        check("midrst_relock_count", int'(relock_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_pulse_high", int'(pll_reset), 1);
        end
        @(negedge clk);
        check("midrst_pulse_low", int'(pll_reset), 0);
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
